// File: rtl/cond_pkg.sv
// Shared types and defaults for the conditional sampling FIFO.
package cond_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } cond_state_t;

endpackage : cond_pkg

// File: rtl/cond_fifo.sv
// Registered-storage FIFO with wrapping pointers and a separate occupancy counter.
// The caller guarantees that it never pushes while full without also popping, and never pops while empty.
module cond_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem   <= '{default: '0};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign rdata = r_mem[r_rptr];
  assign level = r_level;
  assign full  = (r_level == LVL_FULL);
  assign empty = (r_level == '0);

endmodule : cond_fifo

// File: rtl/cond_sample_fifo.sv
// Samples a gated byte while en is high, buffers only changed values, flags drops on full.
// Optional statistics outputs drop_cnt/push_cnt are enabled with `define COND_SAMPLE_STATS_EN.
module cond_sample_fifo
  import cond_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [DATA_W-1:0]        data,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef COND_SAMPLE_STATS_EN
  ,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              push_cnt
`endif
);

  cond_state_t       r_state;
  logic              r_first;
  logic [DATA_W-1:0] r_last;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_need;
  logic w_push;
  logic w_drop;

  // A push is only considered while already tracking and still enabled.
  assign w_pop  = !w_empty && out_ready;
  assign w_need = (r_state != IDLE) && en && (r_first || (data != r_last));
  assign w_push = w_need && (!w_full || w_pop);
  assign w_drop = w_need && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_first    <= 1'b0;
      r_last     <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state <= TRACK;
            r_first <= 1'b1;
          end
        end
        TRACK, HOLD: begin
          if (!en) begin
            r_state <= IDLE;
          end else begin
            if (w_need) begin
              r_last  <= data;
              r_first <= 1'b0;
            end
            if (w_drop) begin
              r_overflow <= 1'b1;
              r_state    <= HOLD;
            end else if (!w_full) begin
              r_state <= TRACK;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef COND_SAMPLE_STATS_EN
  logic [15:0] r_drop_cnt;
  logic [15:0] r_push_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
      r_push_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_push) r_push_cnt <= r_push_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign push_cnt = r_push_cnt;
`endif

  cond_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (data),
    .rdata (out_data),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign overflow  = r_overflow;

endmodule : cond_sample_fifo

// File: tb/tb_cond_sample_fifo.sv
// Bench for cond_sample_fifo: directed vector table plus randomized run against a queue-based model.
module tb_cond_sample_fifo;
  import cond_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] data = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] level;
  logic       overflow;
`ifdef COND_SAMPLE_STATS_EN
  logic [15:0] drop_cnt;
  logic [15:0] push_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cond_sample_fifo #(
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .data      (data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow)
`ifdef COND_SAMPLE_STATS_EN
    ,
    .drop_cnt  (drop_cnt),
    .push_cnt  (push_cnt)
`endif
  );

  // Behavioural reference: a byte queue plus the sampling rules.
  logic [7:0] m_q[$];
  bit         m_active;
  bit         m_first;
  logic [7:0] m_last;
  bit         m_ovf;
  int         m_drops;
  int         m_pushes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit e, input logic [7:0] d, input bit rdy);
    bit pop;
    bit need;
    bit accept;
    if (rst) begin
      m_q.delete();
      m_active = 0; m_first = 0; m_last = '0; m_ovf = 0; m_drops = 0; m_pushes = 0;
      return;
    end
    pop    = (m_q.size() != 0) && rdy;
    need   = m_active && e && (m_first || (d != m_last));
    accept = (m_q.size() < DEPTH) || pop;
    if (pop) void'(m_q.pop_front());
    if (!m_active) begin
      if (e) begin m_active = 1; m_first = 1; end
    end else if (!e) begin
      m_active = 0;
    end else if (need) begin
      if (accept) begin
        m_q.push_back(d);
        m_pushes = (m_pushes + 1) % 65536;
      end else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
      m_last  = d;
      m_first = 0;
    end
  endtask

  task automatic model_check();
    chk("model.out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("model.level", 32'(level), 32'(m_q.size()));
    chk("model.overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) chk("model.out_data", 32'(out_data), 32'(m_q[0]));
`ifdef COND_SAMPLE_STATS_EN
    chk("model.drop_cnt", 32'(drop_cnt), 32'(m_drops));
    chk("model.push_cnt", 32'(push_cnt), 32'(m_pushes));
`endif
  endtask

  task automatic apply(input bit rst, input bit e, input logic [7:0] d, input bit rdy);
    reset = rst; en = e; data = d; out_ready = rdy;
    model_step(rst, e, d, rdy);
    @(posedge clk);
    #1;
    model_check();
  endtask

  typedef struct {
    bit          rst;
    bit          en;
    logic [7:0]  d;
    bit          rdy;
    bit          ev;
    logic [7:0]  ed;
    int          el;
    bit          eo;
    bit          cs;
    cond_state_t es;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit e, logic [7:0] d, bit rdy, bit ev, logic [7:0] ed,
                              int el, bit eo, bit cs, cond_state_t es);
    vec_t v;
    v.rst = r; v.en = e; v.d = d; v.rdy = rdy; v.ev = ev; v.ed = ed;
    v.el = el; v.eo = eo; v.cs = cs; v.es = es;
    tbl.push_back(v);
  endfunction

  initial begin
    // rst en data rdy | valid data level ovf | chk_state state
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, IDLE);   // 0 reset
    add(0, 1, 8'h05, 1, 0, 8'h00, 0, 0, 1, TRACK);  // 1 enter, no push
    add(0, 1, 8'h05, 1, 1, 8'h05, 1, 0, 0, IDLE);   // 2
    add(0, 1, 8'h06, 1, 1, 8'h06, 1, 0, 0, IDLE);
    add(0, 1, 8'h07, 1, 1, 8'h07, 1, 0, 0, IDLE);
    add(0, 1, 8'h08, 1, 1, 8'h08, 1, 0, 0, IDLE);
    add(0, 0, 8'h08, 1, 0, 8'h00, 0, 0, 1, IDLE);   // 6
    add(0, 1, 8'h2A, 0, 0, 8'h00, 0, 0, 0, IDLE);   // 7 held value
    add(0, 1, 8'h2A, 0, 1, 8'h2A, 1, 0, 0, IDLE);
    add(0, 1, 8'h2A, 0, 1, 8'h2A, 1, 0, 0, IDLE);
    add(0, 1, 8'h2A, 0, 1, 8'h2A, 1, 0, 0, IDLE);
    add(0, 1, 8'h2A, 0, 1, 8'h2A, 1, 0, 0, IDLE);
    add(0, 1, 8'h2A, 0, 1, 8'h2A, 1, 0, 1, TRACK);
    add(0, 0, 8'h2A, 1, 0, 8'h00, 0, 0, 0, IDLE);   // 13
    add(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, IDLE);   // 14 fill to full
    add(0, 1, 8'h01, 0, 1, 8'h01, 1, 0, 0, IDLE);
    add(0, 1, 8'h02, 0, 1, 8'h01, 2, 0, 0, IDLE);
    add(0, 1, 8'h03, 0, 1, 8'h01, 3, 0, 0, IDLE);
    add(0, 1, 8'h04, 0, 1, 8'h01, 4, 0, 1, TRACK);
    add(0, 1, 8'h05, 0, 1, 8'h01, 4, 1, 1, HOLD);   // 19 drop
    add(0, 1, 8'h06, 0, 1, 8'h01, 4, 1, 1, HOLD);
    add(0, 0, 8'h06, 1, 1, 8'h02, 3, 1, 1, IDLE);   // 21 drain
    add(0, 0, 8'h06, 1, 1, 8'h03, 2, 1, 0, IDLE);
    add(0, 0, 8'h06, 1, 1, 8'h04, 1, 1, 0, IDLE);
    add(0, 0, 8'h06, 1, 0, 8'h00, 0, 1, 0, IDLE);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, IDLE);   // 25
    add(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, IDLE);   // 26 full push+pop
    add(0, 1, 8'h10, 0, 1, 8'h10, 1, 0, 0, IDLE);
    add(0, 1, 8'h11, 0, 1, 8'h10, 2, 0, 0, IDLE);
    add(0, 1, 8'h12, 0, 1, 8'h10, 3, 0, 0, IDLE);
    add(0, 1, 8'h13, 0, 1, 8'h10, 4, 0, 0, IDLE);
    add(0, 1, 8'h14, 1, 1, 8'h11, 4, 0, 1, TRACK);  // 31
    add(0, 1, 8'h14, 0, 1, 8'h11, 4, 0, 1, TRACK);
    add(0, 0, 8'h14, 1, 1, 8'h12, 3, 0, 0, IDLE);
    add(0, 0, 8'h14, 1, 1, 8'h13, 2, 0, 0, IDLE);
    add(0, 0, 8'h14, 1, 1, 8'h14, 1, 0, 0, IDLE);
    add(0, 0, 8'h14, 1, 0, 8'h00, 0, 0, 0, IDLE);
    add(0, 1, 8'hFE, 0, 0, 8'h00, 0, 0, 0, IDLE);   // 37 wrap
    add(0, 1, 8'hFE, 0, 1, 8'hFE, 1, 0, 0, IDLE);
    add(0, 1, 8'hFF, 0, 1, 8'hFE, 2, 0, 0, IDLE);
    add(0, 1, 8'h00, 0, 1, 8'hFE, 3, 0, 0, IDLE);
    add(0, 0, 8'h00, 0, 1, 8'hFE, 3, 0, 1, IDLE);
    add(0, 1, 8'h00, 0, 1, 8'hFE, 3, 0, 1, TRACK);
    add(0, 1, 8'h00, 0, 1, 8'hFE, 4, 0, 0, IDLE);   // 43 first re-push
    add(0, 1, 8'h01, 0, 1, 8'hFE, 4, 1, 1, HOLD);
    add(0, 0, 8'h01, 1, 1, 8'hFF, 3, 1, 0, IDLE);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, IDLE);   // 46 reset mid-run

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].d, tbl[i].rdy);
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(tbl[i].el));
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tbl[i].eo));
      if (tbl[i].ev) chk($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(tbl[i].ed));
      if (tbl[i].cs) chk($sformatf("vec%0d.state", i), 32'(dut.r_state), 32'(tbl[i].es));
    end

    // Randomized run: small data alphabet so repeats and changes both occur often.
    for (int n = 0; n < 3000; n++) begin
      bit         r;
      bit         e;
      bit         rdy;
      logic [7:0] d;
      r   = ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 99) < 85);
      rdy = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 25 : 60));
      d   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      apply(r, e, d, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cond_sample_fifo
